// File: rtl/enemy_fire_pkg.sv
// Shared types and constants for the enemy fire controller and its LFSR.
package enemy_fire_pkg;

  typedef enum logic [2:0] {
    IDLE_ST,
    COOLDOWN_ST,
    ARM_ST,
    FLIGHT_ST,
    DONE_ST
  } fire_state_t;

  localparam int unsigned LFSR_W = 16;
  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SHOT_W = 4;
  localparam int unsigned RAND_W = 5;

  function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] v);
    return (&v) ? v : v + SHOT_W'(1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the all-zero lockup.
module lfsr16
  import enemy_fire_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              resetN,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= SEED;
    else         state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/enemy_fire_ctrl.sv
// Enemy (pig) fire initiator: cooldown, arm/approve, flight tracking and shot budget.
// Optional macro ENEMY_FIRE_JITTER_EN adds 0..15 random frames to every cooldown reload.
module enemy_fire_ctrl
  import enemy_fire_pkg::*;
#(
  parameter int unsigned       COOLDOWN_FRAMES    = 60,
  parameter int unsigned       ARM_TIMEOUT_FRAMES = 4,
  parameter int unsigned       MAX_SHOTS          = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED          = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     preGame,
  input  logic                     levelStart,
  input  logic                     shooting,
  input  logic                     collision,
  output logic                     timer,
  output logic                     fire,
  output logic signed [RAND_W-1:0] randomValue,
  output logic [SHOT_W-1:0]        shotsFired,
  output logic [SHOT_W-1:0]        hitCount,
  output logic                     busy
);

  fire_state_t               state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt, reload_c;
  logic signed [RAND_W-1:0]  rand_nxt;
  logic [SHOT_W-1:0]         shots_nxt, hits_nxt;
  logic                      hit_seen, hit_seen_nxt;
  logic [LFSR_W-1:0]         lfsr;
  logic                      lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .state  (lfsr)
  );

`ifdef ENEMY_FIRE_JITTER_EN
  assign reload_c    = CNT_W'(COOLDOWN_FRAMES) + CNT_W'(lfsr[7:4]);
  assign lfsr_unused = ^lfsr[15:8];
`else
  assign reload_c    = CNT_W'(COOLDOWN_FRAMES);
  assign lfsr_unused = ^lfsr[15:4];
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE_ST;
      cnt         <= '0;
      randomValue <= '0;
      shotsFired  <= '0;
      hitCount    <= '0;
      hit_seen    <= 1'b0;
      timer       <= 1'b0;
      fire        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      randomValue <= rand_nxt;
      shotsFired  <= shots_nxt;
      hitCount    <= hits_nxt;
      hit_seen    <= hit_seen_nxt;
      // Approval and busy follow the state being entered, so they are registered yet on time
      timer       <= (state_nxt == ARM_ST);
      fire        <= (state_nxt == ARM_ST);
      busy        <= (state_nxt == ARM_ST) || (state_nxt == FLIGHT_ST);
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rand_nxt     = randomValue;
    shots_nxt    = shotsFired;
    hits_nxt     = hitCount;
    hit_seen_nxt = hit_seen;

    if (levelStart) begin
      shots_nxt = '0;
      hits_nxt  = '0;
      if (!preGame) begin
        state_nxt = COOLDOWN_ST;
        cnt_nxt   = reload_c;
      end else begin
        state_nxt = IDLE_ST;
        cnt_nxt   = '0;
      end
    end else if (preGame) begin
      state_nxt = IDLE_ST;
    end else begin
      unique case (state)
        IDLE_ST: begin
          state_nxt = COOLDOWN_ST;
          cnt_nxt   = reload_c;
        end
        COOLDOWN_ST: begin
          // Expiry waits for any previous projectile to clear before arming
          if (cnt == '0) begin
            if (!shooting) begin
              if ((MAX_SHOTS != 0) && (shotsFired == SHOT_W'(MAX_SHOTS))) begin
                state_nxt = DONE_ST;
              end else begin
                rand_nxt  = {1'b0, lfsr[3:0]};
                cnt_nxt   = CNT_W'(ARM_TIMEOUT_FRAMES);
                state_nxt = ARM_ST;
              end
            end
          end else if (startOfFrame) begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        ARM_ST: begin
          if (shooting) begin
            shots_nxt    = sat_inc(shotsFired);
            hit_seen_nxt = 1'b0;
            state_nxt    = FLIGHT_ST;
          end else if (cnt == '0) begin
            cnt_nxt   = reload_c;
            state_nxt = COOLDOWN_ST;
          end else if (startOfFrame) begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        FLIGHT_ST: begin
          if (collision && !hit_seen) begin
            hits_nxt     = sat_inc(hitCount);
            hit_seen_nxt = 1'b1;
          end
          // Entered with shooting high, so the first low cycle is the falling edge
          if (!shooting) begin
            cnt_nxt   = reload_c;
            state_nxt = COOLDOWN_ST;
          end
        end
        DONE_ST: state_nxt = DONE_ST;
        default: state_nxt = IDLE_ST;
      endcase
    end
  end

endmodule
